lbuf_output_timing: RTL

- Output-side timing generator and line-buffer read address generator. Read end of the 40-line source line buffer filled by the scan converter.
- Runs in the output pixel clock domain and drives the scan converter's *_ext inputs: output counters, buffer read addresses, replication phase counters, syncs, DE and border mask.
- Optionally frame-locks output vertical timing to the source VSYNC.

---
 rtl/lbuf_output_timing.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/lbuf_output_timing.sv
// Output timing generator and line-buffer read address generator.
// Drives the scan converter's *_ext inputs from the output pixel clock.
// Optional frame lock to the source VSYNC, compiled in with FRAMELOCK_EN.
module lbuf_output_timing #(
    parameter int unsigned H_TOTAL          = 1650,
    parameter int unsigned H_ACTIVE         = 1280,
    parameter int unsigned H_SYNCLEN        = 40,
    parameter int unsigned H_BACKPORCH      = 220,
    parameter int unsigned V_TOTAL          = 750,
    parameter int unsigned V_ACTIVE         = 720,
    parameter int unsigned V_SYNCLEN        = 5,
    parameter int unsigned V_BACKPORCH      = 20,
    parameter int unsigned H_MULT           = 3,
    parameter int unsigned V_MULT           = 3,
    parameter int unsigned SRC_H_ACTIVE     = 384,
    parameter int unsigned SRC_V_ACTIVE     = 224,
    parameter int unsigned H_SRC_OFFSET     = 64,
    parameter int unsigned V_SRC_OFFSET     = 24,
    parameter int unsigned NUM_LINE_BUFFERS = 40,
    parameter int unsigned V_LOCK_LINE      = 0
) (
    input  logic        PCLK_in,
    input  logic        reset_n,
    input  logic        VSYNC_in,
    output logic [10:0] hcnt_ext,
    output logic [10:0] vcnt_ext,
    output logic [8:0]  hcnt_ext_lbuf,
    output logic [5:0]  vcnt_ext_lbuf,
    output logic [2:0]  hctr_ext,
    output logic [2:0]  vctr_ext,
    output logic        HSYNC_ext,
    output logic        VSYNC_ext,
    output logic        DE_ext,
    output logic        mask_enable_ext,
    output logic        frame_start
);

    localparam int unsigned HA     = H_SYNCLEN + H_BACKPORCH;
    localparam int unsigned VA     = V_SYNCLEN + V_BACKPORCH;
    localparam logic [11:0] HWIN_S = 12'(HA + H_SRC_OFFSET);
    localparam logic [11:0] HWIN_E = 12'(HA + H_SRC_OFFSET + SRC_H_ACTIVE * H_MULT);
    localparam logic [11:0] VWIN_S = 12'(VA + V_SRC_OFFSET);
    localparam logic [11:0] VWIN_E = 12'(VA + V_SRC_OFFSET + SRC_V_ACTIVE * V_MULT);
    localparam logic [11:0] HDE_S  = 12'(HA);
    localparam logic [11:0] HDE_E  = 12'(HA + H_ACTIVE);
    localparam logic [11:0] VDE_S  = 12'(VA);
    localparam logic [11:0] VDE_E  = 12'(VA + V_ACTIVE);
    localparam logic [11:0] HSL    = 12'(H_SYNCLEN);
    localparam logic [11:0] VSL    = 12'(V_SYNCLEN);

    logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [8:0]  hlb_q, hlb_d;
    logic [5:0]  vlb_q, vlb_d;
    logic [2:0]  hctr_q, hctr_d, vctr_q, vctr_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        de_q, de_d, mask_q, mask_d, fs_q, fs_d;
    logic        h_wrap, lock_load;
    logic [11:0] h12, v12, hn12, vn12;
    logic        hwin_cur, vwin_cur, hwin_nxt, vwin_nxt;

`ifdef FRAMELOCK_EN
    logic vs_meta_q, vs_sync_q, vs_prev_q, pending_q, pending_d;

    // Synchronize source VSYNC and keep the previous sample for fall detection
    always_ff @(posedge PCLK_in or negedge reset_n) begin
        if (!reset_n) begin
            vs_meta_q <= 1'b1;
            vs_sync_q <= 1'b1;
            vs_prev_q <= 1'b1;
            pending_q <= 1'b0;
        end else begin
            vs_meta_q <= VSYNC_in;
            vs_sync_q <= vs_meta_q;
            vs_prev_q <= vs_sync_q;
            pending_q <= pending_d;
        end
    end

    // Pending lock: set on a synchronized fall, consumed at the next line wrap
    always_comb begin
        lock_load = h_wrap & pending_q;
        pending_d = pending_q;
        if (lock_load) begin
            pending_d = 1'b0;
        end else if (vs_prev_q && !vs_sync_q) begin
            pending_d = 1'b1;
        end
    end
`else
    wire unused_vsync_in = VSYNC_in;
    assign lock_load = 1'b0;
`endif

    // Next raster position and read addresses
    always_comb begin
        h_wrap = (hcnt_q == 11'(H_TOTAL - 1));
        hcnt_d = h_wrap ? 11'd0 : hcnt_q + 11'd1;
        vcnt_d = vcnt_q;
        if (h_wrap) begin
            if (lock_load) begin
                vcnt_d = 11'(V_LOCK_LINE);
            end else if (vcnt_q == 11'(V_TOTAL - 1)) begin
                vcnt_d = 11'd0;
            end else begin
                vcnt_d = vcnt_q + 11'd1;
            end
        end

        h12      = {1'b0, hcnt_q};
        v12      = {1'b0, vcnt_q};
        hn12     = {1'b0, hcnt_d};
        vn12     = {1'b0, vcnt_d};
        hwin_cur = (h12 >= HWIN_S) && (h12 < HWIN_E);
        vwin_cur = (v12 >= VWIN_S) && (v12 < VWIN_E);
        hwin_nxt = (hn12 >= HWIN_S) && (hn12 < HWIN_E);
        vwin_nxt = (vn12 >= VWIN_S) && (vn12 < VWIN_E);

        // Horizontal phase/column: zero outside the window and on its first pixel
        hlb_d  = 9'd0;
        hctr_d = 3'd0;
        if (hwin_nxt && (hn12 != HWIN_S)) begin
            if (hctr_q == 3'(H_MULT - 1)) begin
                hlb_d = hlb_q + 9'd1;
            end else begin
                hlb_d  = hlb_q;
                hctr_d = hctr_q + 3'd1;
            end
        end

        // Vertical phase/line: only changes at line wraps
        vlb_d  = vlb_q;
        vctr_d = vctr_q;
        if (h_wrap) begin
            vlb_d  = 6'd0;
            vctr_d = 3'd0;
            if (vwin_nxt && vwin_cur && (vn12 != VWIN_S)) begin
                if (vctr_q == 3'(V_MULT - 1)) begin
                    vlb_d = (vlb_q == 6'(NUM_LINE_BUFFERS - 1)) ? 6'd0 : vlb_q + 6'd1;
                end else begin
                    vlb_d  = vlb_q;
                    vctr_d = vctr_q + 3'd1;
                end
            end
        end

        // Sync/DE/mask for the currently shown pixel, presented one cycle later
        hsync_d = !(h12 < HSL);
        vsync_d = !(v12 < VSL);
        de_d    = (h12 >= HDE_S) && (h12 < HDE_E) && (v12 >= VDE_S) && (v12 < VDE_E);
        mask_d  = de_d && !(hwin_cur && vwin_cur);
        fs_d    = (hcnt_q == 11'd0) && (vcnt_q == 11'd0);
    end

    // Timing state registers
    always_ff @(posedge PCLK_in or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_q  <= 11'd0;
            vcnt_q  <= 11'd0;
            hlb_q   <= 9'd0;
            vlb_q   <= 6'd0;
            hctr_q  <= 3'd0;
            vctr_q  <= 3'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            mask_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            hlb_q   <= hlb_d;
            vlb_q   <= vlb_d;
            hctr_q  <= hctr_d;
            vctr_q  <= vctr_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            mask_q  <= mask_d;
            fs_q    <= fs_d;
        end
    end

    assign hcnt_ext        = hcnt_q;
    assign vcnt_ext        = vcnt_q;
    assign hcnt_ext_lbuf   = hlb_q;
    assign vcnt_ext_lbuf   = vlb_q;
    assign hctr_ext        = hctr_q;
    assign vctr_ext        = vctr_q;
    assign HSYNC_ext       = hsync_q;
    assign VSYNC_ext       = vsync_q;
    assign DE_ext          = de_q;
    assign mask_enable_ext = mask_q;
    assign frame_start     = fs_q;

endmodule
